// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core: one round per clock, valid/ready
// handshakes on both sides, optional CBC chaining through an internal chain register.
module aes_enc_iter #(
   parameter int NK = 4,
   localparam int NR = NK + 6,
   localparam int KW = 128 * (NK + 7)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [KW-1:0] word,
   input  logic [127:0]  in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          cbc_en,
   input  logic [127:0]  iv,
   input  logic          iv_load,
   output logic [127:0]  out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_enc_iter: NK must be 4, 6 or 8");
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xt(sh);
      end
      return acc;
   endfunction

   // S-box as GF(2^8) inverse (x^254 via square-and-multiply) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
   fsm_t fsm_reg, fsm_next;

   logic [127:0] state_reg, chain_reg, out_reg;
   logic [3:0]   rnd_reg;
   logic         cbc_en_s, out_valid_reg;
   logic [127:0] rk, rk0, sub_bytes, shift_rows, mix_cols, chain_eff;
   logic         last_round;

   assign rk0        = word[KW-1 -: 128];
   assign rk         = word[KW-1-128*int'(rnd_reg) -: 128];
   assign last_round = (rnd_reg == 4'(NR));
   // A same-cycle iv_load bypasses straight into the first XOR.
   assign chain_eff  = iv_load ? iv : chain_reg;

   for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sub_bytes[127-8*gi -: 8]  = sbox(state_reg[127-8*gi -: 8]);
      assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_cols
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shift_rows[127-32*gi -: 8];
      assign a1 = shift_rows[119-32*gi -: 8];
      assign a2 = shift_rows[111-32*gi -: 8];
      assign a3 = shift_rows[103-32*gi -: 8];
      assign mix_cols[127-32*gi -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      assign mix_cols[119-32*gi -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      assign mix_cols[111-32*gi -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      assign mix_cols[103-32*gi -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_reg <= IDLE;
      else     fsm_reg <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm_reg;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (fsm_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_next = ROUND;
         end
         ROUND: begin
            busy = 1'b1;
            if (last_round) fsm_next = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (out_ready) fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= '0;
         chain_reg     <= '0;
         out_reg       <= '0;
         rnd_reg       <= '0;
         cbc_en_s      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (iv_load) chain_reg <= iv;
               if (in_valid) begin
                  state_reg <= in ^ rk0 ^ (cbc_en ? chain_eff : 128'h0);
                  cbc_en_s  <= cbc_en;
                  rnd_reg   <= 4'd1;
               end
            end
            ROUND: begin
               // The final round skips MixColumns and lands in the output register.
               if (last_round) begin
                  out_reg       <= shift_rows ^ rk;
                  out_valid_reg <= 1'b1;
               end else begin
                  state_reg <= mix_cols ^ rk;
                  rnd_reg   <= rnd_reg + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  if (cbc_en_s) chain_reg <= out_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;

endmodule
